// File: rtl/image_readout_if.sv
// Control, frame-buffer read port and pixel stream of the frame readout block.
// The master modport is the readout side; slave is the host/memory side.
interface image_readout_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 18
);
  logic              io_start;
  logic              io_busy;
  logic              io_convert_enable;
  logic              io_convert_done;
  logic              io_rd_en;
  logic [ADDR_W-1:0] io_rd_addr;
  logic [DATA_W-1:0] io_rd_data;
  logic              io_out_valid;
  logic              io_out_ready;
  logic [DATA_W-1:0] io_out_data;
  logic              io_out_last;
  logic              io_frame_done;

  modport master (
    input  io_start, io_convert_done, io_rd_data, io_out_ready,
    output io_busy, io_convert_enable, io_rd_en, io_rd_addr,
           io_out_valid, io_out_data, io_out_last, io_frame_done
  );

  modport slave (
    output io_start, io_convert_done, io_rd_data, io_out_ready,
    input  io_busy, io_convert_enable, io_rd_en, io_rd_addr,
           io_out_valid, io_out_data, io_out_last, io_frame_done
  );
endinterface

// File: rtl/image_readout.sv
// Frame read-back initiator: triggers conversion, then streams every frame-buffer
// pixel out through a 2-entry skid FIFO with credit-limited synchronous reads.
module image_readout #(
  parameter int WIDTH  = 512,
  parameter int HEIGHT = 512,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 18
) (
  input  logic           clock,
  input  logic           reset,
  image_readout_if.master bus
);
  localparam int N = WIDTH * HEIGHT;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
  localparam logic [ADDR_W:0]   LAST_BEAT = (ADDR_W+1)'(N - 1);

  typedef enum logic [2:0] {S_IDLE, S_CONVERT, S_READ, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   beat_q, beat_d;
  logic              pend_q;
  logic [DATA_W-1:0] mem_q [2];
  logic              wptr_q, rptr_q;
  logic [1:0]        cnt_q, cnt_d;
  logic              rd_en, conv_en, frame_done;
  logic              out_valid, pop, can_issue;
  logic [2:0]        inflight;

  assign out_valid = (cnt_q != 2'd0);
  assign pop       = out_valid && bus.io_out_ready;
  // Buffered plus in-flight words after this cycle's pop; a read is only
  // launched when its returning word is guaranteed a FIFO slot.
  assign inflight  = 3'(cnt_q) + 3'(pend_q) - 3'(pop);
  assign can_issue = (inflight < 3'd2);

  always_comb begin
    state_d    = state_q;
    rd_en      = 1'b0;
    conv_en    = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      S_IDLE:    if (bus.io_start) state_d = S_CONVERT;
      S_CONVERT: begin
        conv_en = 1'b1;
        if (bus.io_convert_done) state_d = S_READ;
      end
      S_READ: if (can_issue) begin
        rd_en = 1'b1;
        if (addr_q == LAST_ADDR) state_d = S_DRAIN;
      end
      S_DRAIN:   if (pop && bus.io_out_last) state_d = S_DONE;
      S_DONE: begin
        frame_done = 1'b1;
        state_d    = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase

    cnt_d = cnt_q + 2'(pend_q) - 2'(pop);
    if (state_q == S_IDLE) begin
      addr_d = '0;
      beat_d = '0;
    end else begin
      addr_d = addr_q + ADDR_W'(rd_en);
      beat_d = beat_q + (ADDR_W+1)'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      beat_q  <= '0;
      pend_q  <= 1'b0;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
      pend_q  <= rd_en;
      if (pend_q) wptr_q <= ~wptr_q;
      if (pop)    rptr_q <= ~rptr_q;
      cnt_q   <= cnt_d;
    end
  end

  // Data storage needs no reset: occupancy gates everything visible.
  always_ff @(posedge clock) begin
    if (pend_q) mem_q[wptr_q] <= bus.io_rd_data;
  end

  assign bus.io_busy           = (state_q != S_IDLE);
  assign bus.io_convert_enable = conv_en;
  assign bus.io_rd_en          = rd_en;
  assign bus.io_rd_addr        = addr_q;
  assign bus.io_out_valid      = out_valid;
  assign bus.io_out_data       = out_valid ? mem_q[rptr_q] : '0;
  assign bus.io_out_last       = out_valid && (beat_q == LAST_BEAT);
  assign bus.io_frame_done     = frame_done;
endmodule
